filter_host_port: RTL and testbench

FILTER_HOST_PORT -- requirements
Module: filter_host_port

---
 rtl/filter_pkg.sv | 16 +
 rtl/sample_skid2.sv | 49 ++++
 rtl/filter_host_port.sv | 123 ++++++++++++
 tb/tb_filter_host_port.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared defaults and FSM encoding for the filter host port.
package filter_pkg;

    localparam int unsigned DW_DEFAULT       = 32;
    localparam int unsigned AW_DEFAULT       = 12;
    localparam int unsigned N_DEFAULT        = 1 << AW_DEFAULT;
    localparam int unsigned RUN_WAIT_DEFAULT = 4098;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        UNLOAD = 2'd3
    } state_t;

endpackage

// File: rtl/sample_skid2.sv
// Two-entry FIFO that holds returned output-buffer samples ahead of the outbound stream.
module sample_skid2 #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count,
    output logic [DW-1:0] head
);

    logic [DW-1:0] slot0;
    logic [DW-1:0] slot1;
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                if (wr_ptr) slot1 <= push_data;
                else        slot0 <= push_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    assign head  = rd_ptr ? slot1 : slot0;
    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

endmodule

// File: rtl/filter_host_port.sv
// Host-side port for a frame filter: loads a frame into the input buffer, kicks the
// engine, waits a fixed latency, then streams the output buffer back out.
module filter_host_port
    import filter_pkg::*;
#(
    parameter int unsigned DW       = DW_DEFAULT,
    parameter int unsigned AW       = AW_DEFAULT,
    parameter int unsigned RUN_WAIT = RUN_WAIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [AW-1:0] in_addr,
    output logic [DW-1:0] in_wdata,
    output logic          in_we,
    output logic          synR,
    output logic [AW-1:0] out_addr,
    input  logic [DW-1:0] out_rdata,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy
);

    state_t        state;
    logic [AW-1:0] wcnt;
    logic [AW-1:0] rcnt;
    logic [AW-1:0] ocnt;
    logic [31:0]   wait_cnt;
    logic          rd_pend;
    logic          rd_done;

    logic          accept;
    logic          pop;
    logic          issue;
    logic          buf_full;
    logic          buf_empty;
    logic [1:0]    buf_count;
    logic [DW-1:0] buf_head;

    assign s_ready  = (state == LOAD);
    assign accept   = rst_n & s_valid & s_ready;
    assign in_we    = accept;
    assign in_addr  = wcnt;
    assign in_wdata = s_data;
    assign synR     = (state == START);
    assign busy     = (state != LOAD);

    assign m_valid  = (state == UNLOAD) & ~buf_empty;
    assign m_data   = buf_head;
    assign m_last   = m_valid & (ocnt == '1);
    assign pop      = m_valid & m_ready;
    assign out_addr = rcnt;

    // Occupancy is taken after this cycle's pop so a streaming consumer sees no bubbles.
    assign issue = (state == UNLOAD) & ~rd_done &
                   (({1'b0, buf_count} + {2'b0, rd_pend}) < (3'd2 + {2'b0, pop}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            wcnt     <= '0;
            rcnt     <= '0;
            ocnt     <= '0;
            wait_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_done  <= 1'b0;
        end else begin
            rd_pend <= issue;
            case (state)
                LOAD: begin
                    if (accept) begin
                        wcnt <= wcnt + AW'(1);
                        if (wcnt == '1) state <= START;
                    end
                end
                START: begin
                    wait_cnt <= 32'd1;
                    state    <= RUN;
                end
                RUN: begin
                    if (wait_cnt == 32'(RUN_WAIT - 1)) state <= UNLOAD;
                    else                               wait_cnt <= wait_cnt + 32'd1;
                end
                UNLOAD: begin
                    if (issue) begin
                        rcnt <= rcnt + AW'(1);
                        if (rcnt == '1) rd_done <= 1'b1;
                    end
                    if (pop) begin
                        ocnt <= ocnt + AW'(1);
                        if (ocnt == '1) begin
                            rd_done <= 1'b0;
                            state   <= LOAD;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    sample_skid2 #(
        .DW (DW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (out_rdata),
        .pop       (pop),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count),
        .head      (buf_head)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(rd_pend && buf_full && !pop));

endmodule

// File: tb/tb_filter_host_port.sv
// Directed bench for filter_host_port: frame load, run latency, unload, stalls and resets.
module tb_filter_host_port;

    localparam int unsigned DW       = 32;
    localparam int unsigned AW       = 12;
    localparam int unsigned N        = 4096;
    localparam int unsigned RUN_WAIT = 4098;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic          in_we;
    logic          synR;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_rdata;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] key;

    filter_host_port #(
        .DW       (DW),
        .AW       (AW),
        .RUN_WAIT (RUN_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_we     (in_we),
        .synR      (synR),
        .out_addr  (out_addr),
        .out_rdata (out_rdata),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Output buffer: one-cycle read latency, contents are address XOR frame key.
    always @(posedge clk) out_rdata <= 32'(out_addr) ^ key;

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b1; s_data = 32'h1234_5678; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({s_ready, in_we, synR, m_valid, m_last, busy} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl: {s_ready,in_we,synR,m_valid,m_last,busy}=%b required 100000",
                     {s_ready, in_we, synR, m_valid, m_last, busy});
        end
        vectors++;
        if (in_addr !== '0 || out_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_addr: in_addr=%0d out_addr=%0d required 0 0", in_addr, out_addr);
        end
        s_valid = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: s_ready=%b busy=%b required 1 0", s_ready, busy);
        end
    endtask

    task automatic load_frame(input bit gaps);
        int unsigned k = 0;
        int unsigned cyc = 0;
        while (k < N && cyc < 4 * N) begin
            @(posedge clk); #1;
            s_valid = gaps ? ((cyc % 8) != 5) : 1'b1;
            s_data  = s_valid ? DW'(k) : (32'hDEAD_0000 | DW'(cyc));
            @(negedge clk);
            vectors++;
            if (s_ready !== 1'b1 || synR !== 1'b0 || in_we !== s_valid) begin
                miscompares++;
                $display("FAIL load_ctrl k=%0d: s_ready=%b synR=%b in_we=%b required 1 0 %b",
                         k, s_ready, synR, in_we, s_valid);
            end
            if (s_valid) begin
                vectors++;
                if (in_addr !== AW'(k) || in_wdata !== DW'(k)) begin
                    miscompares++;
                    $display("FAIL load_write: in_addr=%0d in_wdata=%h required %0d %h",
                             in_addr, in_wdata, k, DW'(k));
                end
                k++;
            end
            cyc++;
        end
        vectors++;
        if (k != N) begin
            miscompares++;
            $display("FAIL load_timeout: beats=%0d required %0d", k, N);
        end
    endtask

    task automatic wait_run(input bit stall);
        s_valid = 1'b1;
        s_data  = '1;
        for (int unsigned c = 0; c <= RUN_WAIT + 1; c++) begin
            @(posedge clk); #1;
            m_ready = stall ? ($urandom_range(0, 99) < 30) : 1'b1;
            @(negedge clk);
            vectors++;
            if (c == 0) begin
                if ({synR, s_ready, busy, in_we} !== 4'b1010) begin
                    miscompares++;
                    $display("FAIL start_cycle: {synR,s_ready,busy,in_we}=%b required 1010",
                             {synR, s_ready, busy, in_we});
                end
            end else if ({synR, s_ready, busy, in_we, m_valid} !== 5'b00100) begin
                miscompares++;
                $display("FAIL run_cycle %0d: {synR,s_ready,busy,in_we,m_valid}=%b required 00100",
                         c, {synR, s_ready, busy, in_we, m_valid});
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic unload_frame(input bit stall, input int unsigned beats);
        int unsigned   idx = 0;
        int unsigned   cyc = 0;
        bit            first = 1'b1;
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        while (idx < beats && cyc < 8 * N) begin
            @(posedge clk); #1;
            m_ready = stall ? ($urandom_range(0, 99) < 30) : 1'b1;
            @(negedge clk);
            if (first || !stall) begin
                vectors++;
                if (m_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL unload_valid beat %0d: m_valid=%b required 1", idx, m_valid);
                end
            end
            first = 1'b0;
            if (prev_stall) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL stall_hold beat %0d: m_valid=%b m_data=%h required 1 %h",
                             idx, m_valid, m_data, prev_data);
                end
            end
            if (m_valid === 1'b1) begin
                vectors++;
                if (m_data !== (DW'(idx) ^ key) || m_last !== (idx == N - 1)) begin
                    miscompares++;
                    $display("FAIL unload_beat %0d: m_data=%h m_last=%b required %h %b",
                             idx, m_data, m_last, DW'(idx) ^ key, (idx == N - 1));
                end
                prev_stall = !m_ready;
                prev_data  = m_data;
                if (m_ready) idx++;
            end else begin
                vectors++;
                if (m_last !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_last: m_last=%b required 0", m_last);
                end
                prev_stall = 1'b0;
            end
            cyc++;
        end
        vectors++;
        if (idx != beats) begin
            miscompares++;
            $display("FAIL unload_timeout: beats=%0d required %0d", idx, beats);
        end
        if (beats == N) begin
            @(posedge clk); #1;
            m_ready = 1'b1;
            @(negedge clk);
            vectors++;
            if ({s_ready, busy, m_valid, synR} !== 4'b1000 || in_addr !== '0 || out_addr !== '0) begin
                miscompares++;
                $display("FAIL frame_end: {s_ready,busy,m_valid,synR}=%b in_addr=%0d out_addr=%0d required 1000 0 0",
                         {s_ready, busy, m_valid, synR}, in_addr, out_addr);
            end
        end
    endtask

    task automatic test_stream();
        key = 32'hA5A5_A5A5;
        load_frame(1'b0);
        wait_run(1'b0);
        unload_frame(1'b0, N);
    endtask

    task automatic test_gaps_stall();
        key = 32'h3C3C_0F0F;
        load_frame(1'b1);
        wait_run(1'b1);
        unload_frame(1'b1, N);
    endtask

    task automatic test_reset_mid();
        key = 32'h0F0F_1234;
        load_frame(1'b0);
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        #1;
        vectors++;
        if ({s_ready, in_we, synR, m_valid, m_last, busy} !== 6'b100000 ||
            in_addr !== '0 || out_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_in_run: ctrl=%b in_addr=%0d out_addr=%0d required 100000 0 0",
                     {s_ready, in_we, synR, m_valid, m_last, busy}, in_addr, out_addr);
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b1;

        load_frame(1'b0);
        wait_run(1'b0);
        unload_frame(1'b0, 100);
        @(posedge clk); #1;
        rst_n = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        #1;
        vectors++;
        if ({s_ready, in_we, synR, m_valid, m_last, busy} !== 6'b100000 ||
            in_addr !== '0 || out_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_in_unload: ctrl=%b in_addr=%0d out_addr=%0d required 100000 0 0",
                     {s_ready, in_we, synR, m_valid, m_last, busy}, in_addr, out_addr);
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_back_to_back();
        key = 32'h1357_9BDF;
        load_frame(1'b0);
        wait_run(1'b0);
        unload_frame(1'b0, N);
        key = 32'hC0DE_F00D;
        load_frame(1'b0);
        wait_run(1'b0);
        unload_frame(1'b0, N);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        key     = 32'hA5A5_A5A5;
        test_reset();
        test_stream();
        test_gaps_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with %0d vectors applied, required completion", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
